// File: rtl/reg_access_master.sv
// Register access master: turns a valid/ready command into a strobe-based LMAC
// register read or write, with a WAIT-state timeout and a held response.
module reg_access_master #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              reg_clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic [ADDR_W-1:0] host_addr,
  output logic [DATA_W-1:0] host_wdata,
  output logic              reg_rd_start,
  output logic              reg_wr_start,
  input  logic              reg_rd_done_out,
  input  logic              reg_wr_done_out,
  input  logic [DATA_W-1:0] mac_regdout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [4:0] {
    IDLE  = 5'h01,
    ADDR  = 5'h02,
    ISSUE = 5'h04,
    WAIT  = 5'h08,
    RESP  = 5'h10
  } state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              lat_wr, lat_wr_d;
  logic [ADDR_W-1:0] host_addr_d;
  logic [DATA_W-1:0] host_wdata_d;
  logic              rd_start_d, wr_start_d;
  logic              rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic              rsp_err_d;
  logic              done_match;

  // Decoded from the state register only, so cmd_valid never reaches cmd_ready.
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Next-state and next-value logic for every registered output.
  always_comb begin
    state_d      = state;
    cnt_d        = '0;
    lat_wr_d     = lat_wr;
    host_addr_d  = host_addr;
    host_wdata_d = host_wdata;
    rd_start_d   = 1'b0;
    wr_start_d   = 1'b0;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata;
    rsp_err_d    = rsp_err;
    done_match   = lat_wr ? reg_wr_done_out : reg_rd_done_out;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          lat_wr_d     = cmd_wr;
          host_addr_d  = cmd_addr;
          host_wdata_d = cmd_wr ? cmd_wdata : '0;
          state_d      = ADDR;
        end
      end
      ADDR: begin
        rd_start_d = ~lat_wr;
        wr_start_d = lat_wr;
        state_d    = ISSUE;
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt + CNT_W'(1);
        // Done takes priority over a timeout landing in the same cycle.
        if (done_match) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = lat_wr ? '0 : mac_regdout;
        end else if (cnt == CNT_LAST) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d      = IDLE;
          host_addr_d  = '0;
          host_wdata_d = '0;
          rsp_rdata_d  = '0;
          rsp_err_d    = 1'b0;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d      = IDLE;
        lat_wr_d     = 1'b0;
        host_addr_d  = '0;
        host_wdata_d = '0;
        rsp_rdata_d  = '0;
        rsp_err_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge reg_clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      lat_wr       <= 1'b0;
      host_addr    <= '0;
      host_wdata   <= '0;
      reg_rd_start <= 1'b0;
      reg_wr_start <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      lat_wr       <= lat_wr_d;
      host_addr    <= host_addr_d;
      host_wdata   <= host_wdata_d;
      reg_rd_start <= rd_start_d;
      reg_wr_start <= wr_start_d;
      rsp_valid    <= rsp_valid_d;
      rsp_rdata    <= rsp_rdata_d;
      rsp_err      <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_reg_access_master.sv
// Directed bench for reg_access_master: read, write, timeout, done/timeout race,
// wrong-done rejection, backpressure, and mid-transaction reset.
module tb_reg_access_master;

  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned TIMEOUT_CYC = 16;

  logic              reg_clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              reg_rd_start;
  logic              reg_wr_start;
  logic              reg_rd_done_out;
  logic              reg_wr_done_out;
  logic [DATA_W-1:0] mac_regdout;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;

  int n_checks = 0;
  int n_pass   = 0;

  reg_access_master #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .reg_clk        (reg_clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_wr         (cmd_wr),
    .cmd_addr       (cmd_addr),
    .cmd_wdata      (cmd_wdata),
    .host_addr      (host_addr),
    .host_wdata     (host_wdata),
    .reg_rd_start   (reg_rd_start),
    .reg_wr_start   (reg_wr_start),
    .reg_rd_done_out(reg_rd_done_out),
    .reg_wr_done_out(reg_wr_done_out),
    .mac_regdout    (mac_regdout),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .busy           (busy)
  );

  always #5 reg_clk = ~reg_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Runs one command from a negedge until rsp_valid is seen; cyc counts negedges
  // after acceptance. done is driven dly cycles after the strobe cycle (dly<0: never).
  task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                         input int dly, input logic [31:0] rdata, input logic wrong_done,
                         output int n_rd, output int n_wr, output int n_wait,
                         output int s_cyc, output int r_cyc,
                         output logic [15:0] a_addr, output logic [15:0] a_s,
                         output logic [31:0] wd_s);
    int s;
    s = -1; n_rd = 0; n_wr = 0; n_wait = 0; r_cyc = -1;
    a_addr = '0; a_s = '0; wd_s = '0;
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge reg_clk);
      if (cyc == 1) begin
        cmd_valid = 1'b0;
        a_addr    = host_addr;
      end
      reg_rd_done_out = 1'b0;
      reg_wr_done_out = 1'b0;
      mac_regdout     = 32'h0BAD_0BAD;
      if (reg_rd_start) begin n_rd++; s = cyc; a_s = host_addr; wd_s = host_wdata; end
      if (reg_wr_start) begin n_wr++; s = cyc; a_s = host_addr; wd_s = host_wdata; end
      if (rsp_valid) begin r_cyc = cyc; break; end
      if (s > 0 && cyc > s) n_wait++;
      if (s > 0 && wrong_done && cyc >= s) begin
        if (wr) reg_rd_done_out = 1'b1; else reg_wr_done_out = 1'b1;
      end
      if (s > 0 && dly >= 0 && cyc == s + dly) begin
        if (wr) reg_wr_done_out = 1'b1; else reg_rd_done_out = 1'b1;
        mac_regdout = rdata;
      end
    end
    reg_rd_done_out = 1'b0;
    reg_wr_done_out = 1'b0;
    s_cyc = s;
    check("rsp_seen", 64'(r_cyc > 0), 64'd1);
  endtask

  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    @(negedge reg_clk);
    rsp_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(rsp_valid), 64'd0);
    check({tag, "_idle"}, 64'({cmd_ready, busy}), 64'b10);
    check({tag, "_host_clr"}, 64'({host_addr, host_wdata}), 64'd0);
  endtask

  int n_rd, n_wr, n_wait, s_cyc, r_cyc;
  logic [15:0] a_addr, a_s;
  logic [31:0] wd_s;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    reg_rd_done_out = 1'b0; reg_wr_done_out = 1'b0; mac_regdout = '0; rsp_ready = 1'b0;
    @(negedge reg_clk);
    @(negedge reg_clk);
    check("rst_ready_busy", 64'({cmd_ready, busy}), 64'b10);
    check("rst_strobes", 64'({reg_rd_start, reg_wr_start}), 64'd0);
    check("rst_host", 64'({host_addr, host_wdata}), 64'd0);
    check("rst_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'd0);
    reset = 1'b0;

    // Read, done 3 cycles after strobe
    run_txn(1'b0, 16'h0010, 32'hFFFF_FFFF, 3, 32'hDEAD_BEEF, 1'b0,
            n_rd, n_wr, n_wait, s_cyc, r_cyc, a_addr, a_s, wd_s);
    check("rd_nrd", 64'(n_rd), 64'd1);
    check("rd_nwr", 64'(n_wr), 64'd0);
    check("rd_strobe_lat", 64'(s_cyc), 64'd2);
    check("rd_addr_phase", 64'(a_addr), 64'h0010);
    check("rd_addr_strobe", 64'(a_s), 64'h0010);
    check("rd_wdata_zero", 64'(wd_s), 64'd0);
    check("rd_nwait", 64'(n_wait), 64'd3);
    check("rd_rdata", 64'(rsp_rdata), 64'hDEAD_BEEF);
    check("rd_err", 64'(rsp_err), 64'd0);
    finish_rsp("rd");

    // Write, immediate done: response on cycle 4 gives a 5-cycle period
    run_txn(1'b1, 16'h0024, 32'h1234_5678, 1, 32'h0, 1'b0,
            n_rd, n_wr, n_wait, s_cyc, r_cyc, a_addr, a_s, wd_s);
    check("wr_nwr", 64'(n_wr), 64'd1);
    check("wr_nrd", 64'(n_rd), 64'd0);
    check("wr_addr", 64'(a_s), 64'h0024);
    check("wr_wdata", 64'(wd_s), 64'h1234_5678);
    check("wr_rsp_cyc", 64'(r_cyc), 64'd4);
    check("wr_rdata", 64'(rsp_rdata), 64'd0);
    check("wr_err", 64'(rsp_err), 64'd0);
    finish_rsp("wr");

    // Timeout, issued back-to-back; late done during RESP ignored
    run_txn(1'b0, 16'h0030, 32'h0, -1, 32'h0, 1'b0,
            n_rd, n_wr, n_wait, s_cyc, r_cyc, a_addr, a_s, wd_s);
    check("to_strobe_lat", 64'(s_cyc), 64'd2);
    check("to_nwait", 64'(n_wait), 64'd16);
    check("to_err", 64'(rsp_err), 64'd1);
    check("to_rdata", 64'(rsp_rdata), 64'd0);
    reg_rd_done_out = 1'b1;
    mac_regdout = 32'h7777_7777;
    @(negedge reg_clk);
    reg_rd_done_out = 1'b0;
    check("to_late_done", 64'({rsp_valid, rsp_err, rsp_rdata}), {31'd0, 1'b1, 1'b1, 32'd0});
    finish_rsp("to");

    // Done on the timeout cycle wins
    run_txn(1'b0, 16'h0044, 32'h0, 16, 32'hA5A5_5A5A, 1'b0,
            n_rd, n_wr, n_wait, s_cyc, r_cyc, a_addr, a_s, wd_s);
    check("race_nwait", 64'(n_wait), 64'd16);
    check("race_err", 64'(rsp_err), 64'd0);
    check("race_rdata", 64'(rsp_rdata), 64'hA5A5_5A5A);
    finish_rsp("race");

    // Write-done during a read's WAIT is ignored; then hold off the response
    run_txn(1'b0, 16'h0048, 32'h0, 5, 32'hCAFE_F00D, 1'b1,
            n_rd, n_wr, n_wait, s_cyc, r_cyc, a_addr, a_s, wd_s);
    check("wd_nwait", 64'(n_wait), 64'd5);
    check("wd_err", 64'(rsp_err), 64'd0);
    check("wd_rdata", 64'(rsp_rdata), 64'hCAFE_F00D);
    for (int i = 0; i < 10; i++) begin
      @(negedge reg_clk);
      check("bp_rsp_hold", 64'({rsp_valid, rsp_err, rsp_rdata}), {31'd0, 1'b1, 1'b0, 32'hCAFE_F00D});
      check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    finish_rsp("bp");

    // Reset during WAIT aborts without a response; later done ignored
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 16'h0060;
    for (int i = 0; i < 5; i++) begin
      @(negedge reg_clk);
      cmd_valid = 1'b0;
    end
    check("rw_in_wait", 64'({busy, rsp_valid}), 64'b10);
    reset = 1'b1;
    @(negedge reg_clk);
    reset = 1'b0;
    check("rw_idle", 64'({cmd_ready, busy}), 64'b10);
    check("rw_outs", 64'({rsp_valid, rsp_err, reg_rd_start, reg_wr_start, host_addr}), 64'd0);
    check("rw_rdata", 64'(rsp_rdata), 64'd0);
    reg_rd_done_out = 1'b1;
    @(negedge reg_clk);
    reg_rd_done_out = 1'b0;
    @(negedge reg_clk);
    @(negedge reg_clk);
    check("rw_late_done", 64'({busy, rsp_valid}), 64'd0);

    // Reset on the strobe cycle drops the strobe at that edge
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 16'h0070; cmd_wdata = 32'h0F0F_0F0F;
    @(negedge reg_clk);
    cmd_valid = 1'b0;
    @(negedge reg_clk);
    check("rs_strobe", 64'(reg_wr_start), 64'd1);
    reset = 1'b1;
    @(negedge reg_clk);
    reset = 1'b0;
    check("rs_strobe_drop", 64'({reg_wr_start, host_wdata}), 64'd0);
    check("rs_idle", 64'({cmd_ready, busy, rsp_valid}), 64'b100);

    // Recovery read after reset
    run_txn(1'b0, 16'h55AA, 32'h0, 1, 32'h0123_4567, 1'b0,
            n_rd, n_wr, n_wait, s_cyc, r_cyc, a_addr, a_s, wd_s);
    check("rec_rdata", 64'(rsp_rdata), 64'h0123_4567);
    check("rec_addr", 64'(a_s), 64'h55AA);
    finish_rsp("rec");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
